gsim_param_solver: RTL and testbench
====================================

Name: gsim_param_solver

Overview:
- Parametrised Gauss-Seidel solver for the fixed banded N×N system used by the solver subsystem. Row i of the matrix: 20 on the diagonal, -13 at ±1, 6 at ±2, -1 at ±3; out-of-range neighbours contribute 0.
- Receives N offsets b, then iterates until either a programmable tolerance or a programmable iteration cap is reached.
- Streams the N solution words out under ready/valid backpressure, then reports the iteration count and the convergence status.

Parameters:
N, 16, number of unknowns (≥4)
B_W, 16, signed width of b_in
X_W, 32, signed width of each x word; 16 fraction bits
IT_W, 10, width of iter_max and iter_done

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
in_en  in  1  b_in valid; accepted only in RECV
b_in  in  B_W  signed offset b[i], natural order i=0..N-1
iter_max  in  IT_W  iteration cap, sampled with b[0]
tol  in  X_W  unsigned convergence tolerance, sampled with b[0]
out_ready  in  1  downstream accepts x_out
out_valid  out  1  x_out valid (SEND state)
x_out  out  X_W  x[out_idx], signed Q(X_W-16).16
out_idx  out  clog2(N)  index of current x_out
iter_done  out  IT_W  iterations executed; valid during SEND
converged  out  1  tolerance met; valid during SEND
busy  out  1  high in CALC and SEND

Behaviour:
- Reset (reset=0, asynchronous): state←RECV, all counters←0, x[]←0, b[]←0. Outputs: out_valid=0, x_out=0, out_idx=0, iter_done=0, converged=0, busy=0. A reset asserted in any state aborts the frame with no partial output.
- States: RECV, CALC, SEND.
- RECV:
  - Each cycle with in_en=1 stores b[cnt]←b_in, then cnt++.
  - iter_max and tol are latched on the cycle with cnt=0.
  - An effective iter_max of 0 is treated as 1.
  - On acceptance of b[N-1]: x[]←0, cnt←0, state←CALC.
- CALC:
  - Updates one unknown per cycle, i=cnt in natural order; one iteration takes N cycles.
  - S = b[i]·2^16 + 13(x[i-1]+x[i+1]) − 6(x[i-2]+x[i+2]) + (x[i-3]+x[i+3]).
  - x[i-k] are this iteration's new values; x[i+k] are the previous iteration's values (Gauss-Seidel).
  - S is computed at full precision: at least X_W+8 bits, no intermediate overflow.
  - x_new = floor(S/20), i.e. rounded toward −∞. The result is bit-exact to the golden model; implementation method is free (reciprocal-multiply with correction, etc.).
  - x_new then saturates to the signed X_W range.
  - Per iteration, track maxd = max |x_new − x_old| over all i, with unsigned comparison.
  - At the edge writing x[N-1]: iter_done++.
  - If maxd ≤ tol: converged←1, go to SEND. Else if iter_done+1 == iter_max: converged←0, go to SEND. Else start the next iteration.
  - Total CALC cycles = N·iter_done exactly. First out_valid appears N·iter_done edges after the edge accepting b[N-1].
- SEND:
  - out_valid=1, x_out=x[out_idx], out_idx starts at 0.
  - A transfer occurs when out_valid & out_ready. out_idx++ on each transfer.
  - When out_ready=0, x_out and out_idx are held stable.
  - After the transfer of idx N-1: state←RECV, out_valid←0 the next cycle. iter_done and converged hold their values until b[0] of the next frame is accepted.
- in_en outside RECV is ignored; b[] is not modified.
- No state has a timeout; backpressure may stall SEND indefinitely.

Test Plan:
- N=16, all b=0, tol=0, iter_max=200 → converged=1, iter_done=1, 16 x_out words all 0, first out_valid 16 edges after last b.
- N=16, all b=20, iter_max=1, tol=0 → iter_done=1, converged=0, x[0]=0x00010000, x[1]=108134 (floor(33·65536/20)). x[2..15] are bit-exact to the golden model.
- N=16, random b in ±32767, iter_max=200, tol=0x10 → converged=1 with iter_done<200. All 16 words match the golden model; out_idx sequence is 0..15.
- SEND backpressure: drop out_ready for 3 cycles while out_idx=5 → x_out/out_idx held, no word lost or duplicated. Toggle in_en with random b_in during SEND → no effect on outputs or next frame.
- X_W=24, all b=32767, iter_max=1 → x[0]=8388607 (saturated); negative b=−32768 → x[0]=−8388608.
- Drive reset low mid-CALC (iteration 3) → outputs at reset values immediately. Next full frame after release produces correct results.

Source files
------------

// File: rtl/gsim_param_solver.sv
// Gauss-Seidel solver for the fixed banded system (20, -13, 6, -1 bands).
// Receives N offsets, iterates one unknown per cycle, then streams x[] out.
module gsim_param_solver #(
    parameter int N    = 16,
    parameter int B_W  = 16,
    parameter int X_W  = 32,
    parameter int IT_W = 10
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_en,
    input  logic signed [B_W-1:0]  b_in,
    input  logic [IT_W-1:0]        iter_max,
    input  logic [X_W-1:0]         tol,
    input  logic                   out_ready,
    output logic                   out_valid,
    output logic signed [X_W-1:0]  x_out,
    output logic [$clog2(N)-1:0]   out_idx,
    output logic [IT_W-1:0]        iter_done,
    output logic                   converged,
    output logic                   busy
);

    localparam int CW = $clog2(N);
    localparam int MW = (B_W + 16 > X_W) ? (B_W + 16) : X_W;
    localparam int SW = MW + 8;

    localparam logic signed [SW-1:0] C1   = SW'(1);
    localparam logic signed [SW-1:0] C6   = SW'(6);
    localparam logic signed [SW-1:0] C13  = SW'(13);
    localparam logic signed [SW-1:0] C20  = SW'(20);
    localparam logic signed [SW-1:0] XMAX = {{(SW-X_W+1){1'b0}}, {(X_W-1){1'b1}}};
    localparam logic signed [SW-1:0] XMIN = ~XMAX;

    typedef enum logic [1:0] {RECV, CALC, SEND} state_t;
    state_t state, state_nx;

    logic signed [X_W-1:0] x_r [N];
    logic signed [B_W-1:0] b_r [N];
    logic [CW-1:0]         cnt;
    logic [IT_W-1:0]       iter_max_r;
    logic [X_W-1:0]        tol_r;
    logic [X_W-1:0]        maxd;

    logic signed [SW-1:0]  lo_v [1:3];
    logic signed [SW-1:0]  hi_v [1:3];
    logic signed [SW-1:0]  b_sh, acc, quo, rem;
    logic signed [X_W-1:0] x_new, x_old;
    logic signed [X_W:0]   dif;
    logic [X_W:0]          adif;
    logic [X_W-1:0]        maxd_nx;
    logic                  last_row, hit_tol, hit_cap;

    // Rows below cnt already hold this iteration's values, rows above the previous one.
    always_comb begin
        for (int unsigned k = 1; k <= 3; k++) begin
            lo_v[k] = '0;
            hi_v[k] = '0;
            if (int'(cnt) >= int'(k))
                lo_v[k] = SW'(x_r[cnt - CW'(k)]);
            if (int'(cnt) + int'(k) < N)
                hi_v[k] = SW'(x_r[cnt + CW'(k)]);
        end
        b_sh = signed'({{(SW-B_W-16){b_r[cnt][B_W-1]}}, b_r[cnt], 16'h0000});
        acc  = b_sh + C13 * (lo_v[1] + hi_v[1]) - C6 * (lo_v[2] + hi_v[2])
             + lo_v[3] + hi_v[3];
        // Division truncates toward zero; step down once for negative inexact results.
        quo = acc / C20;
        rem = acc - quo * C20;
        if (acc < 0 && rem != 0)
            quo = quo - C1;
        if (quo > XMAX)
            x_new = XMAX[X_W-1:0];
        else if (quo < XMIN)
            x_new = XMIN[X_W-1:0];
        else
            x_new = quo[X_W-1:0];
        x_old   = x_r[cnt];
        dif     = {x_new[X_W-1], x_new} - {x_old[X_W-1], x_old};
        adif    = dif[X_W] ? unsigned'(-dif) : unsigned'(dif);
        maxd_nx = (cnt == '0) ? '0 : maxd;
        if (adif[X_W-1:0] > maxd_nx)
            maxd_nx = adif[X_W-1:0];
        last_row = (cnt == CW'(N-1));
        hit_tol  = (maxd_nx <= tol_r);
        hit_cap  = ((iter_done + IT_W'(1)) == iter_max_r);
    end

    always_comb begin
        state_nx = state;
        case (state)
            RECV: if (in_en && cnt == CW'(N-1)) state_nx = CALC;
            CALC: if (last_row && (hit_tol || hit_cap)) state_nx = SEND;
            SEND: if (out_ready && out_idx == CW'(N-1)) state_nx = RECV;
            default: state_nx = RECV;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= RECV;
        else
            state <= state_nx;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < N; i++) begin
                x_r[i] <= '0;
                b_r[i] <= '0;
            end
            cnt        <= '0;
            iter_max_r <= '0;
            tol_r      <= '0;
            maxd       <= '0;
            out_idx    <= '0;
            iter_done  <= '0;
            converged  <= 1'b0;
        end else begin
            case (state)
                RECV: if (in_en) begin
                    b_r[cnt] <= b_in;
                    if (cnt == '0) begin
                        iter_max_r <= (iter_max == '0) ? IT_W'(1) : iter_max;
                        tol_r      <= tol;
                        iter_done  <= '0;
                        converged  <= 1'b0;
                    end
                    if (cnt == CW'(N-1)) begin
                        cnt <= '0;
                        for (int unsigned i = 0; i < N; i++)
                            x_r[i] <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                CALC: begin
                    x_r[cnt] <= x_new;
                    maxd     <= maxd_nx;
                    if (last_row) begin
                        cnt       <= '0;
                        iter_done <= iter_done + IT_W'(1);
                        if (hit_tol)
                            converged <= 1'b1;
                        else if (hit_cap)
                            converged <= 1'b0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                SEND: if (out_ready)
                    out_idx <= (out_idx == CW'(N-1)) ? '0 : out_idx + CW'(1);
                default: ;
            endcase
        end
    end

    assign out_valid = (state == SEND);
    assign busy      = (state != RECV);
    assign x_out     = out_valid ? x_r[out_idx] : '0;

endmodule

// File: tb/tb_gsim_param_solver.sv
// Directed bench for gsim_param_solver: 32-bit and 24-bit instances, bench-side Gauss-Seidel model.
module tb_gsim_param_solver;
    localparam int N = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               reset, in_en, in_en24, out_ready;
    logic signed [15:0] b_in;
    logic [9:0]         iter_max;
    logic [31:0]        tol;

    logic               ov, conv, busy;
    logic signed [31:0] xo;
    logic [3:0]         oi;
    logic [9:0]         itd;
    logic               ov24, conv24, busy24;
    logic signed [23:0] xo24;
    logic [3:0]         oi24;
    logic [9:0]         itd24;

    gsim_param_solver #(.N(N), .B_W(16), .X_W(32), .IT_W(10)) dut (
        .clk(clk), .reset(reset), .in_en(in_en), .b_in(b_in), .iter_max(iter_max),
        .tol(tol), .out_ready(out_ready), .out_valid(ov), .x_out(xo), .out_idx(oi),
        .iter_done(itd), .converged(conv), .busy(busy));

    gsim_param_solver #(.N(N), .B_W(16), .X_W(24), .IT_W(10)) dut24 (
        .clk(clk), .reset(reset), .in_en(in_en24), .b_in(b_in), .iter_max(iter_max),
        .tol(tol[23:0]), .out_ready(out_ready), .out_valid(ov24), .x_out(xo24), .out_idx(oi24),
        .iter_done(itd24), .converged(conv24), .busy(busy24));

    int n_checks = 0;
    int n_fail   = 0;

    longint fb [N];
    int     fimax;
    longint ftol;
    longint mx [N];
    int     mit;
    bit     mconv;
    longint rx [N];
    int     ridx [N];
    int     rlat, rit;
    bit     rconv, rto;

    function automatic longint at(input int j);
        return (j >= 0 && j < N) ? mx[j] : 64'sd0;
    endfunction

    task automatic model_run(input int xw);
        longint hi, lo, s, q, nv, d, maxd;
        int imax;
        hi = (longint'(1) <<< (xw - 1)) - 1;
        lo = -(longint'(1) <<< (xw - 1));
        for (int i = 0; i < N; i++) mx[i] = 0;
        imax = (fimax == 0) ? 1 : fimax;
        mit = 0;
        mconv = 0;
        for (int it = 1; it <= 1024; it++) begin
            maxd = 0;
            for (int i = 0; i < N; i++) begin
                s = fb[i] * 65536 + 13 * (at(i-1) + at(i+1)) - 6 * (at(i-2) + at(i+2))
                  + at(i-3) + at(i+3);
                q = (s >= 0) ? s / 20 : -((-s + 19) / 20);
                nv = (q > hi) ? hi : ((q < lo) ? lo : q);
                d = nv - mx[i];
                if (d < 0) d = -d;
                if (d > maxd) maxd = d;
                mx[i] = nv;
            end
            mit = it;
            if (maxd <= ftol) begin
                mconv = 1;
                break;
            end
            if (it == imax) break;
        end
    endtask

    task automatic send_frame(input bit t24);
        @(posedge clk); #1;
        for (int i = 0; i < N; i++) begin
            if (t24) in_en24 = 1'b1; else in_en = 1'b1;
            b_in     = 16'(fb[i]);
            iter_max = 10'(fimax);
            tol      = 32'(ftol);
            @(posedge clk); #1;
        end
        in_en   = 1'b0;
        in_en24 = 1'b0;
    endtask

    task automatic receive(input bit t24);
        int guard;
        rto  = 0;
        rlat = 0;
        while (!(t24 ? ov24 : ov) && rlat < 5000) begin
            @(posedge clk); #1;
            rlat++;
        end
        if (!(t24 ? ov24 : ov)) begin
            rto = 1;
            return;
        end
        rit   = t24 ? int'(itd24) : int'(itd);
        rconv = t24 ? conv24 : conv;
        for (int k = 0; k < N; k++) begin
            guard = 0;
            while (!(t24 ? ov24 : ov) && guard < 100) begin
                @(posedge clk); #1;
                guard++;
            end
            rx[k]   = t24 ? longint'(xo24) : longint'(xo);
            ridx[k] = t24 ? int'(oi24) : int'(oi);
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset;
        reset = 1'b0;
        #1;
        if (ov !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", ov); end
        n_checks++;
        if (xo !== 32'sd0) begin n_fail++; $display("FAIL reset_x_out got %0d want 0", xo); end
        n_checks++;
        if (oi !== 4'd0) begin n_fail++; $display("FAIL reset_out_idx got %0d want 0", oi); end
        n_checks++;
        if (itd !== 10'd0) begin n_fail++; $display("FAIL reset_iter_done got %0d want 0", itd); end
        n_checks++;
        if (conv !== 1'b0) begin n_fail++; $display("FAIL reset_converged got %b want 0", conv); end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
        n_checks++;
        @(posedge clk); #1;
        reset = 1'b1;
    endtask

    task automatic test_zero;
        for (int i = 0; i < N; i++) fb[i] = 0;
        fimax = 200;
        ftol  = 0;
        send_frame(0);
        receive(0);
        if (rto !== 1'b0) begin n_fail++; $display("FAIL zero_timeout got %b want 0", rto); end
        n_checks++;
        if (rlat != 16) begin n_fail++; $display("FAIL zero_latency got %0d want 16", rlat); end
        n_checks++;
        if (rit != 1) begin n_fail++; $display("FAIL zero_iter_done got %0d want 1", rit); end
        n_checks++;
        if (rconv !== 1'b1) begin n_fail++; $display("FAIL zero_converged got %b want 1", rconv); end
        n_checks++;
        for (int k = 0; k < N; k++) begin
            if (rx[k] != 0) begin n_fail++; $display("FAIL zero_word[%0d] got %0d want 0", k, rx[k]); end
            n_checks++;
            if (ridx[k] != k) begin n_fail++; $display("FAIL zero_idx[%0d] got %0d want %0d", k, ridx[k], k); end
            n_checks++;
        end
        if (ov !== 1'b0) begin n_fail++; $display("FAIL zero_valid_after got %b want 0", ov); end
        n_checks++;
        if (itd !== 10'd1) begin n_fail++; $display("FAIL zero_iter_hold got %0d want 1", itd); end
        n_checks++;
        if (conv !== 1'b1) begin n_fail++; $display("FAIL zero_conv_hold got %b want 1", conv); end
        n_checks++;
    endtask

    task automatic test_cap_one;
        for (int i = 0; i < N; i++) fb[i] = 20;
        fimax = 1;
        ftol  = 0;
        model_run(32);
        send_frame(0);
        receive(0);
        if (rto !== 1'b0) begin n_fail++; $display("FAIL cap_timeout got %b want 0", rto); end
        n_checks++;
        if (rlat != 16) begin n_fail++; $display("FAIL cap_latency got %0d want 16", rlat); end
        n_checks++;
        if (rit != 1) begin n_fail++; $display("FAIL cap_iter_done got %0d want 1", rit); end
        n_checks++;
        if (rconv !== 1'b0) begin n_fail++; $display("FAIL cap_converged got %b want 0", rconv); end
        n_checks++;
        if (rx[0] != 65536) begin n_fail++; $display("FAIL cap_x0 got %0d want 65536", rx[0]); end
        n_checks++;
        if (rx[1] != 108134) begin n_fail++; $display("FAIL cap_x1 got %0d want 108134", rx[1]); end
        n_checks++;
        for (int k = 2; k < N; k++) begin
            if (rx[k] != mx[k]) begin n_fail++; $display("FAIL cap_word[%0d] got %0d want %0d", k, rx[k], mx[k]); end
            n_checks++;
        end
    endtask

    task automatic test_random;
        for (int i = 0; i < N; i++) fb[i] = longint'($urandom_range(0, 65534)) - 32767;
        fimax = 200;
        ftol  = 16;
        model_run(32);
        send_frame(0);
        receive(0);
        if (rto !== 1'b0) begin n_fail++; $display("FAIL rand_timeout got %b want 0", rto); end
        n_checks++;
        if (rconv !== 1'b1) begin n_fail++; $display("FAIL rand_converged got %b want 1", rconv); end
        n_checks++;
        if (rit != mit || rit >= 200) begin n_fail++; $display("FAIL rand_iter_done got %0d want %0d", rit, mit); end
        n_checks++;
        if (rlat != 16 * mit) begin n_fail++; $display("FAIL rand_latency got %0d want %0d", rlat, 16 * mit); end
        n_checks++;
        for (int k = 0; k < N; k++) begin
            if (rx[k] != mx[k]) begin n_fail++; $display("FAIL rand_word[%0d] got %0d want %0d", k, rx[k], mx[k]); end
            n_checks++;
            if (ridx[k] != k) begin n_fail++; $display("FAIL rand_idx[%0d] got %0d want %0d", k, ridx[k], k); end
            n_checks++;
        end
    endtask

    task automatic test_back_to_back;
        int k, guard;
        bit stalled;
        for (int i = 0; i < N; i++) fb[i] = longint'($urandom_range(0, 65535)) - 32768;
        fimax = 3;
        ftol  = 0;
        model_run(32);
        send_frame(0);
        guard = 0;
        while (!ov && guard < 1000) begin
            @(posedge clk); #1;
            guard++;
        end
        if (ov !== 1'b1) begin n_fail++; $display("FAIL bp_timeout got %b want 1", ov); end
        n_checks++;
        if (itd != 10'(mit)) begin n_fail++; $display("FAIL bp_iter_done got %0d want %0d", itd, mit); end
        n_checks++;
        if (conv !== mconv) begin n_fail++; $display("FAIL bp_converged got %b want %b", conv, mconv); end
        n_checks++;
        k = 0;
        stalled = 0;
        guard = 0;
        while (k < N && guard < 200) begin
            guard++;
            if (ov) begin
                if (oi == 4'd5 && !stalled) begin
                    stalled = 1;
                    out_ready = 1'b0;
                    for (int s = 0; s < 3; s++) begin
                        @(posedge clk); #1;
                        if (oi !== 4'd5) begin n_fail++; $display("FAIL bp_hold_idx got %0d want 5", oi); end
                        n_checks++;
                        if (longint'(xo) != mx[5]) begin n_fail++; $display("FAIL bp_hold_x got %0d want %0d", xo, mx[5]); end
                        n_checks++;
                    end
                    out_ready = 1'b1;
                end
                rx[k]   = longint'(xo);
                ridx[k] = int'(oi);
                k++;
            end
            in_en = 1'($urandom_range(0, 1));
            b_in  = 16'($urandom);
            @(posedge clk); #1;
        end
        in_en = 1'b0;
        if (k != N) begin n_fail++; $display("FAIL bp_count got %0d want %0d", k, N); end
        n_checks++;
        for (int j = 0; j < N; j++) begin
            if (rx[j] != mx[j]) begin n_fail++; $display("FAIL bp_word[%0d] got %0d want %0d", j, rx[j], mx[j]); end
            n_checks++;
            if (ridx[j] != j) begin n_fail++; $display("FAIL bp_idx[%0d] got %0d want %0d", j, ridx[j], j); end
            n_checks++;
        end
        if (ov !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL bp_idle_after got %b%b want 00", ov, busy); end
        n_checks++;
        // Next frame must be unaffected by in_en activity during SEND.
        for (int i = 0; i < N; i++) fb[i] = longint'($urandom_range(0, 65535)) - 32768;
        fimax = 4;
        ftol  = 0;
        model_run(32);
        send_frame(0);
        receive(0);
        if (rlat != 16 * mit) begin n_fail++; $display("FAIL next_latency got %0d want %0d", rlat, 16 * mit); end
        n_checks++;
        for (int j = 0; j < N; j++) begin
            if (rx[j] != mx[j]) begin n_fail++; $display("FAIL next_word[%0d] got %0d want %0d", j, rx[j], mx[j]); end
            n_checks++;
        end
    endtask

    task automatic test_saturation;
        for (int i = 0; i < N; i++) fb[i] = 32767;
        fimax = 1;
        ftol  = 0;
        model_run(24);
        send_frame(1);
        receive(1);
        if (rto !== 1'b0) begin n_fail++; $display("FAIL satp_timeout got %b want 0", rto); end
        n_checks++;
        if (rx[0] != 8388607) begin n_fail++; $display("FAIL satp_x0 got %0d want 8388607", rx[0]); end
        n_checks++;
        for (int k = 1; k < N; k++) begin
            if (rx[k] != mx[k]) begin n_fail++; $display("FAIL satp_word[%0d] got %0d want %0d", k, rx[k], mx[k]); end
            n_checks++;
        end
        for (int i = 0; i < N; i++) fb[i] = -32768;
        model_run(24);
        send_frame(1);
        receive(1);
        if (rto !== 1'b0) begin n_fail++; $display("FAIL satn_timeout got %b want 0", rto); end
        n_checks++;
        if (rx[0] != -8388608) begin n_fail++; $display("FAIL satn_x0 got %0d want -8388608", rx[0]); end
        n_checks++;
        for (int k = 1; k < N; k++) begin
            if (rx[k] != mx[k]) begin n_fail++; $display("FAIL satn_word[%0d] got %0d want %0d", k, rx[k], mx[k]); end
            n_checks++;
        end
        if (rit != 1 || rconv !== 1'b0) begin n_fail++; $display("FAIL satn_status got %0d/%b want 1/0", rit, rconv); end
        n_checks++;
    endtask

    task automatic test_reset_mid_calc;
        for (int i = 0; i < N; i++) fb[i] = longint'($urandom_range(0, 65535)) - 32768;
        fimax = 200;
        ftol  = 0;
        send_frame(0);
        repeat (36) @(posedge clk);
        #1;
        if (busy !== 1'b1 || itd !== 10'd2) begin n_fail++; $display("FAIL mid_calc_state got busy=%b iter=%0d want 1/2", busy, itd); end
        n_checks++;
        reset = 1'b0;
        #1;
        if (ov !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL mid_reset_flags got %b%b want 00", ov, busy); end
        n_checks++;
        if (itd !== 10'd0 || conv !== 1'b0) begin n_fail++; $display("FAIL mid_reset_status got %0d/%b want 0/0", itd, conv); end
        n_checks++;
        if (xo !== 32'sd0 || oi !== 4'd0) begin n_fail++; $display("FAIL mid_reset_data got %0d/%0d want 0/0", xo, oi); end
        n_checks++;
        @(posedge clk); #1;
        reset = 1'b1;
        for (int i = 0; i < N; i++) fb[i] = longint'($urandom_range(0, 65535)) - 32768;
        fimax = 5;
        ftol  = 0;
        model_run(32);
        send_frame(0);
        receive(0);
        if (rto !== 1'b0) begin n_fail++; $display("FAIL post_reset_timeout got %b want 0", rto); end
        n_checks++;
        if (rit != mit) begin n_fail++; $display("FAIL post_reset_iter got %0d want %0d", rit, mit); end
        n_checks++;
        for (int k = 0; k < N; k++) begin
            if (rx[k] != mx[k]) begin n_fail++; $display("FAIL post_reset_word[%0d] got %0d want %0d", k, rx[k], mx[k]); end
            n_checks++;
        end
    endtask

    initial begin
        reset     = 1'b0;
        in_en     = 1'b0;
        in_en24   = 1'b0;
        out_ready = 1'b1;
        b_in      = '0;
        iter_max  = '0;
        tol       = '0;
        test_reset;
        test_zero;
        test_cap_one;
        test_random;
        test_back_to_back;
        test_saturation;
        test_reset_mid_calc;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
